// File: rtl/instructions_pkg.sv
// rtl/instructions_pkg.sv - shared fetch-path types and core-level defaults
package instructions_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int FETCHQ_DEPTH = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// rtl/fetch_queue_ram.sv - entry storage: one synchronous write port, one async read port
module fetch_queue_ram
    import instructions_pkg::*;
#(
    parameter int WIDTH = $bits(fetch_entry_t),
    parameter int DEPTH = FETCHQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Deliberately not reset: only pointers and count define validity.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - elastic fetch-to-decode queue; FETCHQ_BYPASS_EN enables empty-queue bypass
module inst_fetch_queue
    import instructions_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = FETCHQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_inst,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     occ;
    logic [2*XLEN-1:0] rd_data;
    logic              empty;
    logic              push;
    logic              pop;
    logic              bypass_take;
    logic              wr_en;
    logic              rd_en;

    assign empty    = (occ == '0);
    assign in_ready = rstn & ~flush & (occ != FULL_COUNT);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

`ifdef FETCHQ_BYPASS_EN
    // An empty queue forwards the incoming entry; if decode takes it, it is never stored.
    assign out_valid   = rstn & ~flush & (~empty | in_valid);
    assign out_pc      = empty ? in_pc   : rd_data[2*XLEN-1:XLEN];
    assign out_inst    = empty ? in_inst : rd_data[XLEN-1:0];
    assign bypass_take = empty & push & out_ready;
`else
    assign out_valid   = rstn & ~flush & ~empty;
    assign out_pc      = rd_data[2*XLEN-1:XLEN];
    assign out_inst    = rd_data[XLEN-1:0];
    assign bypass_take = 1'b0;
`endif

    assign wr_en = push & ~bypass_take;
    assign rd_en = pop & ~bypass_take;

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + CW'(wr_en) - CW'(rd_en);
        end
    end

    assign count = occ;

    fetch_queue_ram #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_inst}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule
